lsu_writeback: RTL and testbench
================================

# lsu_writeback

Memory-access and write-back stage of the PYGMY-V32I core. It sits downstream of `decode` and its execute stage and consumes the control bundle that `decode` emits: `reg_we`, `mem_we`, `mem_re`, `hb` and `ul`. It performs data-memory loads and stores over a req/ack bus, with byte-lane alignment and sign/zero extension. It drives the register-file write port (`rd_i`, `rd_ptr_i`, `reg_we_i`) back into `decode`.

## Interface
- `WB_SKIP_X0`, default 1: when 1, `reg_we_o` is never asserted for `rd_ptr` = 0.
- `clk_i`  in  1  core clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  execute result and control valid.
- `ready_o`  out  1  block can accept `valid_i`; high only in IDLE.
- `alu_result_i`  in  32  ALU result; byte address for loads and stores.
- `store_data_i`  in  32  rs2 value for stores.
- `rd_ptr_i`  in  5  destination register.
- `reg_we_i`, `mem_we_i`, `mem_re_i`, `ul_i`  in  1 each  control bits from `decode`.
- `hb_i`  in  2  access size: 01 byte, 10 half, 00 word, 11 treated as word.
- `mem_req_o`  out  1  bus request, held until ack.
- `mem_we_o`  out  1  write strobe, valid with `mem_req_o`.
- `mem_addr_o`  out  32  word address; `[1:0]` are always 0.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_be_o`  out  4  byte enables.
- `mem_ack_i`  in  1  one-cycle completion; `mem_rdata_i` valid with it.
- `mem_rdata_i`  in  32  read word.
- `rd_o`  out  32  write-back data.
- `rd_ptr_o`  out  5  write-back register.
- `reg_we_o`  out  1  one-cycle write-back pulse.
- `misalign_o`  out  1  one-cycle misaligned-access pulse (only meaningful with the config macro).

## Operation
- FSM has three states: IDLE, BUS, WB.
- IDLE with `valid_i`: latch all inputs.
  - `mem_re_i` or `mem_we_i` set → BUS.
  - Otherwise → WB with `rd` = `alu_result_i`.
- If `mem_re_i` and `mem_we_i` are both set, the access is a store.
- BUS:
  - `mem_req_o` = 1; address, data, byte enables and `mem_we_o` are held stable.
  - On `mem_ack_i`: load → WB; store → IDLE with no write-back.
- WB:
  - `reg_we_o` pulses for one cycle if latched `reg_we` is set (subject to `WB_SKIP_X0`).
  - Then → IDLE.
- Store lanes (`off` = address bits [1:0]):
  - Byte: data replicated ×4, `mem_be_o` = 0001 << `off`.
  - Half: low half replicated ×2, `mem_be_o` = 0011 << {`off[1]`, 0}.
  - Word: `mem_be_o` = 1111.
- Load extraction:
  - Byte: `rdata[8*off +: 8]`.
  - Half: `rdata[16*off[1] +: 16]`.
  - Result is sign-extended to 32 bits, or zero-extended when `ul` is set; word passes through.
- Loads with the `reg_we` bit clear complete on the bus but never pulse `reg_we_o`.

## Timing
- Reset values: state IDLE, `ready_o` 0 while `rst_i` is high and 1 on the first cycle after it drops; every other output 0.
- All outputs are registered.
- Non-memory op: `valid_i` sampled at edge N → `reg_we_o` high in cycle N+1 → `ready_o` high in cycle N+2.
- Load: `mem_req_o` rises at N+1.
  - Ack sampled at edge M → `reg_we_o` in cycle M+1.
  - Minimum latency is 2 cycles (ack in the first request cycle).
- Store: `mem_req_o` drops and `ready_o` rises in the cycle after the ack.
- `valid_i` while `ready_o` = 0 is ignored; upstream must hold it.
- `mem_ack_i` outside BUS is ignored, including a late ack after reset.
- `rst_i` asserted mid-access: `mem_req_o` drops at the next edge; the pending write-back is discarded.
- Bus wait is unbounded; there is no timeout.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A half access with `off[0]` = 1, or a word access with `off` ≠ 0, is trapped.
  - A trapped access skips BUS, goes to WB with `reg_we_o` suppressed, and pulses `misalign_o` in that cycle.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - `misalign_o` is tied to 0.
  - Offending low address bits are ignored (half uses `off[1]` only; word ignores `off`).

## Structure
- Shared `pygmy_pkg` holds:
  - FSM state enum.
  - `hb` size encodings (`HB_BYTE` = 01, `HB_HALF` = 10, `HB_WORD` = 00).
- Sub-module `lsu_align`: combinational store-lane/byte-enable generation and load extract/extend; instantiated once.

## Test plan
- ALU op, `reg_we` = 1, `rd` = 5, result 0x1234 → `reg_we_o` pulse next cycle with `rd_o` = 0x00001234, `rd_ptr_o` = 5; no `mem_req_o`.
- Signed byte load at 0x103, ack after 3 wait cycles with rdata 0x80AABBCC → `mem_addr_o` = 0x100, `rd_o` = 0xFFFFFF80; the same with `ul` = 1 → 0x00000080.
- Half store 0xDEADBEEF at 0x22 → `mem_wdata_o` = 0xBEEFBEEF, `mem_be_o` = 1100, `mem_we_o` = 1; no `reg_we_o`.
- `rd_ptr` = 0 with `WB_SKIP_X0` = 1 → no `reg_we_o` pulse; `ready_o` returns 2 cycles after accept.
- `rst_i` asserted during BUS, then ack arrives the cycle after → `mem_req_o` low, no write-back, state IDLE.
- Word load at 0x102: with `LSU_MISALIGN_CHECK_EN`, `misalign_o` pulses and there is no bus request; without it, `mem_addr_o` = 0x100 and the full word is written back.

Source files
------------

// File: rtl/pygmy_pkg.sv
// pygmy_pkg: shared FSM state, access-size encodings and misalignment helper for the PYGMY-V32I core.
package pygmy_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB} state_t;
  localparam logic [1:0] HB_BYTE = 2'b01;
  localparam logic [1:0] HB_HALF = 2'b10;
  localparam logic [1:0] HB_WORD = 2'b00;
  // hb = 11 falls through to the word rule
  function automatic logic misaligned(input logic [1:0] hb, input logic [1:0] off);
    return hb == HB_BYTE ? 1'b0 : hb == HB_HALF ? off[0] : off != 2'b00;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational store lane replication/byte enables and load extract with sign/zero extension.
module lsu_align
  import pygmy_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_hb,
  input  logic        i_ul,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_ldata
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = i_rdata[{i_off, 3'b000} +: 8];
  assign w_h = i_rdata[{i_off[1], 4'b0000} +: 16];
  always_comb begin
    o_wdata = i_hb == HB_BYTE ? {4{i_sdata[7:0]}} : i_hb == HB_HALF ? {2{i_sdata[15:0]}} : i_sdata;
    o_be    = i_hb == HB_BYTE ? 4'b0001 << i_off : i_hb == HB_HALF ? 4'b0011 << {i_off[1], 1'b0} : 4'b1111;
    o_ldata = i_hb == HB_BYTE ? {{24{~i_ul & w_b[7]}}, w_b} :
              i_hb == HB_HALF ? {{16{~i_ul & w_h[15]}}, w_h} : i_rdata;
  end
endmodule

// File: rtl/lsu_writeback.sv
// lsu_writeback: memory-access and write-back stage; loads/stores over a req/ack bus, then register write-back.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module lsu_writeback
  import pygmy_pkg::*;
#(
  parameter bit WB_SKIP_X0 = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_ptr_i,
  input  logic        reg_we_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  input  logic        ul_i,
  input  logic [1:0]  hb_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rd_o,
  output logic [4:0]  rd_ptr_o,
  output logic        reg_we_o,
  output logic        misalign_o
);
  state_t      r_state, w_next;
  logic [1:0]  r_off, r_hb;
  logic        r_ul, r_store, r_wb_en;
  logic        r_ready, r_req, r_we, r_reg_we, r_mis;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_be;
  logic [4:0]  r_rd_ptr;
  logic        w_accept, w_mem, w_mis, w_ack, w_store, w_we_ok;
  logic [1:0]  w_off, w_hb;
  logic        w_ul;
  logic [31:0] w_wdata, w_ldata;
  logic [3:0]  w_be;
  assign w_accept = r_state == S_IDLE && valid_i;
  assign w_mem    = mem_re_i | mem_we_i;
  assign w_ack    = r_state == S_BUS && mem_ack_i;
  assign w_store  = r_state == S_IDLE ? mem_we_i : r_store;
  assign w_we_ok  = reg_we_i && !(WB_SKIP_X0 && rd_ptr_i == 5'd0);
`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis = w_accept && w_mem && misaligned(hb_i, alu_result_i[1:0]);
`else
  assign w_mis = 1'b0;
`endif
  // One aligner serves both directions: live inputs while accepting a store, latched size/offset for load data
  assign w_off = r_state == S_IDLE ? alu_result_i[1:0] : r_off;
  assign w_hb  = r_state == S_IDLE ? hb_i : r_hb;
  assign w_ul  = r_state == S_IDLE ? ul_i : r_ul;
  lsu_align u_align (
    .i_off   (w_off),
    .i_hb    (w_hb),
    .i_ul    (w_ul),
    .i_sdata (store_data_i),
    .i_rdata (mem_rdata_i),
    .o_wdata (w_wdata),
    .o_be    (w_be),
    .o_ldata (w_ldata)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == S_IDLE ? (valid_i ? (w_mem && !w_mis ? S_BUS : S_WB) : S_IDLE) :
             r_state == S_BUS  ? (mem_ack_i ? (r_store ? S_IDLE : S_WB) : S_BUS) : S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {r_off, r_hb, r_ul, r_store, r_wb_en} <= '0;
      {r_ready, r_req, r_we, r_reg_we, r_mis} <= '0;
      {r_addr, r_wdata, r_rd, r_be, r_rd_ptr} <= '0;
    end else begin
      r_ready  <= w_next == S_IDLE;
      r_req    <= w_next == S_BUS;
      r_we     <= w_next == S_BUS && w_store;
      r_mis    <= w_mis;
      r_reg_we <= (w_accept && w_next == S_WB && !w_mis && w_we_ok) || (w_ack && !r_store && r_wb_en);
      if (w_accept) begin
        r_off    <= alu_result_i[1:0];
        r_hb     <= hb_i;
        r_ul     <= ul_i;
        r_store  <= mem_we_i;
        r_wb_en  <= w_we_ok;
        r_addr   <= {alu_result_i[31:2], 2'b00};
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_rd_ptr <= rd_ptr_i;
        r_rd     <= alu_result_i;
      end
      if (w_ack && !r_store) r_rd <= w_ldata;
    end
  end
  assign ready_o     = r_ready;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign rd_o        = r_rd;
  assign rd_ptr_o    = r_rd_ptr;
  assign reg_we_o    = r_reg_we;
  assign misalign_o  = r_mis;
endmodule

// File: tb/tb_lsu_writeback.sv
// tb_lsu_writeback: vector table plus hand sequences; write-backs checked against a scoreboard queue.
module tb_lsu_writeback;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, valid_i = 0, reg_we_i = 0, mem_we_i = 0, mem_re_i = 0, ul_i = 0, mem_ack_i = 0;
  logic [31:0] alu_result_i = 0, store_data_i = 0, mem_rdata_i = 0;
  logic [4:0]  rd_ptr_i = 0;
  logic [1:0]  hb_i = 0;
  logic ready_o, mem_req_o, mem_we_o, reg_we_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rd_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  rd_ptr_o;

  lsu_writeback dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_ptr_i(rd_ptr_i),
    .reg_we_i(reg_we_i), .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .ul_i(ul_i), .hb_i(hb_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .rd_o(rd_o), .rd_ptr_o(rd_ptr_o), .reg_we_o(reg_we_o),
    .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] alu, sdata;
    logic [4:0]  rd;
    logic        reg_we, we, re, ul;
    logic [1:0]  hb;
    logic [31:0] rdata;
    int          w;
    logic        exp_wb;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;
  typedef struct { logic [31:0] rd; logic [4:0] ptr; } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t tv[12];
  vec_t v;
  int n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_wb: got pulse rd_ptr=%0d rd=%h want none", rd_ptr_o, rd_o);
      end else begin
        e_mon = sb.pop_front();
        chk("wb_rd", rd_o, e_mon.rd);
        chk("wb_ptr", {27'b0, rd_ptr_o}, {27'b0, e_mon.ptr});
      end
    end
`ifndef LSU_MISALIGN_CHECK_EN
    if (misalign_o !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL misalign_tied: got %b want 0", misalign_o);
    end
`endif
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && ready_o !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", {31'b0, ready_o}, 1);
  endtask

  task automatic issue(vec_t x);
    @(negedge clk);
    valid_i = 1; alu_result_i = x.alu; store_data_i = x.sdata; rd_ptr_i = x.rd;
    reg_we_i = x.reg_we; mem_we_i = x.we; mem_re_i = x.re; ul_i = x.ul; hb_i = x.hb;
    if (x.exp_wb) sb.push_back('{x.exp_rd, x.rd});
    @(posedge clk); #1;
    valid_i = 0;
  endtask

  task automatic run_vec(vec_t x);
    wait_ready();
    issue(x);
    @(negedge clk);
    if (x.re | x.we) begin
      chk("bus_req", {31'b0, mem_req_o}, 1);
      chk("bus_addr", mem_addr_o, x.exp_addr);
      chk("bus_we", {31'b0, mem_we_o}, {31'b0, x.we});
      if (x.we) begin
        chk("bus_wdata", mem_wdata_o, x.exp_wdata);
        chk("bus_be", {28'b0, mem_be_o}, {28'b0, x.exp_be});
      end
      repeat (x.w) @(negedge clk);
      chk("bus_req_held", {31'b0, mem_req_o}, 1);
      mem_ack_i = 1; mem_rdata_i = x.rdata;
      @(posedge clk); #1;
      mem_ack_i = 0; mem_rdata_i = 0;
      @(negedge clk);
      chk("after_ack_req", {31'b0, mem_req_o}, 0);
      chk("after_ack_wb", {31'b0, reg_we_o}, {31'b0, x.exp_wb});
      if (x.we) chk("store_ready", {31'b0, ready_o}, 1);
    end else begin
      chk("alu_noreq", {31'b0, mem_req_o}, 0);
      chk("alu_wb", {31'b0, reg_we_o}, {31'b0, x.exp_wb});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // alu, sdata, rd, reg_we, we, re, ul, hb, rdata, wait, exp_wb, exp_rd, exp_addr, exp_wdata, exp_be
    tv[0]  = '{32'h1234, 0, 5, 1, 0, 0, 0, 2'b00, 0, 0, 1, 32'h1234, 0, 0, 0};
    tv[1]  = '{32'h103, 0, 7, 1, 0, 1, 0, 2'b01, 32'h80AABBCC, 3, 1, 32'hFFFFFF80, 32'h100, 0, 0};
    tv[2]  = '{32'h103, 0, 7, 1, 0, 1, 1, 2'b01, 32'h80AABBCC, 3, 1, 32'h00000080, 32'h100, 0, 0};
    tv[3]  = '{32'h22, 32'hDEADBEEF, 9, 1, 1, 0, 0, 2'b10, 0, 1, 0, 0, 32'h20, 32'hBEEFBEEF, 4'b1100};
    tv[4]  = '{32'h42, 0, 10, 1, 0, 1, 0, 2'b10, 32'h80017FFF, 0, 1, 32'hFFFF8001, 32'h40, 0, 0};
    tv[5]  = '{32'h40, 0, 11, 1, 0, 1, 1, 2'b10, 32'h1234F00D, 1, 1, 32'h0000F00D, 32'h40, 0, 0};
    tv[6]  = '{32'h11, 32'h123456A5, 1, 0, 1, 0, 0, 2'b01, 0, 2, 0, 0, 32'h10, 32'hA5A5A5A5, 4'b0010};
    tv[7]  = '{32'h30, 32'hCAFEF00D, 2, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h30, 32'hCAFEF00D, 4'b1111};
    tv[8]  = '{32'h8, 0, 3, 0, 0, 1, 0, 2'b00, 32'h55555555, 1, 0, 0, 32'h8, 0, 0};
    tv[9]  = '{32'h1, 0, 4, 1, 0, 1, 0, 2'b01, 32'h00007F00, 0, 1, 32'h7F, 32'h0, 0, 0};
    tv[10] = '{32'hFFFFFFFF, 0, 31, 1, 0, 0, 0, 2'b01, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0};
    tv[11] = '{32'h20, 0, 6, 1, 0, 1, 0, 2'b11, 32'hA0B0C0D0, 0, 1, 32'hA0B0C0D0, 32'h20, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 0);
    chk("rst_req", {31'b0, mem_req_o}, 0);
    chk("rst_wb", {31'b0, reg_we_o}, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, ready_o}, 1);

    // Late ack while idle must be ignored
    mem_ack_i = 1; mem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1 mem_ack_i = 0; mem_rdata_i = 0;
    @(negedge clk);
    chk("idle_ack_req", {31'b0, mem_req_o}, 0);
    chk("idle_ack_ready", {31'b0, ready_o}, 1);

    // ALU op timing: pulse at N+1, ready back at N+2
    issue(tv[0]);
    @(negedge clk);
    chk("alu_pulse", {31'b0, reg_we_o}, 1);
    chk("alu_busy", {31'b0, ready_o}, 0);
    chk("alu_noreq_t", {31'b0, mem_req_o}, 0);
    @(negedge clk);
    chk("alu_ready_n2", {31'b0, ready_o}, 1);

    // x0 destination: no pulse, ready still returns two cycles after accept
    v = '{32'h77, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    issue(v);
    @(negedge clk);
    chk("x0_busy", {31'b0, ready_o}, 0);
    @(negedge clk);
    chk("x0_ready", {31'b0, ready_o}, 1);

    for (int i = 0; i < 12; i++) run_vec(tv[i]);

    // Reset during BUS, ack one cycle later: dropped request, no write-back
    wait_ready();
    v = '{32'h200, 0, 12, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    issue(v);
    @(negedge clk);
    chk("rstbus_req", {31'b0, mem_req_o}, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("rstbus_req_drop", {31'b0, mem_req_o}, 0);
    @(posedge clk); #1 mem_ack_i = 0; mem_rdata_i = 0;
    @(negedge clk);
    chk("rstbus_idle_req", {31'b0, mem_req_o}, 0);
    chk("rstbus_ready", {31'b0, ready_o}, 1);

    // Word load at 0x102
`ifdef LSU_MISALIGN_CHECK_EN
    v = '{32'h102, 0, 13, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    issue(v);
    @(negedge clk);
    chk("mis_pulse", {31'b0, misalign_o}, 1);
    chk("mis_noreq", {31'b0, mem_req_o}, 0);
    @(negedge clk);
    chk("mis_clear", {31'b0, misalign_o}, 0);
`else
    v = '{32'h102, 0, 13, 1, 0, 1, 0, 2'b00, 32'h89ABCDEF, 1, 1, 32'h89ABCDEF, 32'h100, 0, 0};
    run_vec(v);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
